memory_access_unit: RTL and testbench

Memory-access (MA) pipeline stage placed directly after the execute stage. Holds the EX/MA pipeline register, issues word-addressed data-memory requests over a req/gnt/rvalid handshake, and aligns store data and byte enables. Sign/zero-extends load data and produces the MA/WB register for write-back. Stalls the pipeline while a memory transaction is outstanding and supplies the MA forwarding operand to the execute stage.

---
 rtl/multicore_pkg.sv | 35 +++
 rtl/load_align.sv | 26 ++
 rtl/memory_access_unit.sv | 170 +++++++++++++++++
 tb/tb_memory_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types and constants for the multicore pipeline: load/store size encodings,
// memory-access FSM states, write-back source select and an alignment helper.
package multicore_pkg;

  localparam int DATA_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int RDEST_W   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU} t_ldop;
  typedef enum logic [1:0] {SB, SH, SW} t_sop;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} t_ma_state;
  typedef enum logic [1:0] {MTR_ALU = 2'b00, MTR_MEM = 2'b01, MTR_PC4 = 2'b10} t_memtoreg;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] off, input logic is_store,
                                         input t_ldop ldop, input t_sop sop);
    logic mis;
    mis = 1'b0;
    if (is_store) begin
      case (sop)
        SH:      mis = off[0];
        SW:      mis = |off;
        default: mis = 1'b0;
      endcase
    end else begin
      case (ldop)
        LH, LHU: mis = off[0];
        LW:      mis = |off;
        default: mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_align
  import multicore_pkg::*;
(
  input  logic [DATA_SIZE-1:0] i_rdata,
  input  logic [1:0]           i_offset,
  input  t_ldop                i_ldop,
  output logic [DATA_SIZE-1:0] o_data
);

  logic [DATA_SIZE-1:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    shifted = i_rdata >> {i_offset, 3'b000};
    o_data  = shifted;
    case (i_ldop)
      LB:      o_data = {{(DATA_SIZE-8){shifted[7]}}, shifted[7:0]};
      LBU:     o_data = {{(DATA_SIZE-8){1'b0}}, shifted[7:0]};
      LH:      o_data = {{(DATA_SIZE-16){shifted[15]}}, shifted[15:0]};
      LHU:     o_data = {{(DATA_SIZE-16){1'b0}}, shifted[15:0]};
      default: o_data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MA pipeline stage: EX/MA register, req/gnt/rvalid data-memory master, store lane
// alignment, load extension and the MA/WB register feeding write-back.
module memory_access_unit
  import multicore_pkg::*;
(
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic [DATA_SIZE-1:0] i_exe_calc,
  input  logic [DATA_SIZE-1:0] i_exe_wdata,
  input  logic [DATA_SIZE-1:0] i_pcplus4,
  input  logic [RDEST_W-1:0]   i_rdest,
  input  logic                 i_cu_regwrite,
  input  logic                 i_cu_memwrite,
  input  logic                 i_cu_memaccess,
  input  logic [1:0]           i_cu_memtoreg,
  input  t_ldop                i_ldop,
  input  t_sop                 i_sop,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [DATA_SIZE-1:0] o_dmem_addr,
  output logic [DATA_SIZE-1:0] o_dmem_wdata,
  output logic [3:0]           o_dmem_be,
  input  logic                 i_dmem_gnt,
  input  logic                 i_dmem_rvalid,
  input  logic [DATA_SIZE-1:0] i_dmem_rdata,
  output logic                 o_stall,
  output logic [DATA_SIZE-1:0] o_ma_op,
  output logic [DATA_SIZE-1:0] o_wb_alu,
  output logic [DATA_SIZE-1:0] o_wb_load,
  output logic [DATA_SIZE-1:0] o_wb_pcplus4,
  output logic [RDEST_W-1:0]   o_wb_rdest,
  output logic [1:0]           o_wb_memtoreg,
  output logic                 o_wb_regwrite,
  output logic                 o_misaligned
);

  t_ma_state            state_q, state_d;
  logic [DATA_SIZE-1:0] calc_q, wdata_q, pcplus4_q;
  logic [RDEST_W-1:0]   rdest_q;
  t_ldop                ldop_q;
  t_sop                 sop_q;
  logic                 regwrite_q, memwrite_q, memaccess_q, valid_q;
  logic [1:0]           memtoreg_q;

  logic [DATA_SIZE-1:0] wb_alu_q, wb_load_q, wb_pcplus4_q;
  logic [RDEST_W-1:0]   wb_rdest_q;
  logic [1:0]           wb_memtoreg_q;
  logic                 wb_regwrite_q, misaligned_q;

  logic                 capture, start_mem, rsp_done, ma_mis, wb_take_alu;
  logic [DATA_SIZE-1:0] load_data;

  assign o_stall     = (state_q == ST_REQ) | ((state_q == ST_RSP) & ~i_dmem_rvalid);
  assign o_dmem_req  = (state_q == ST_REQ);
  assign capture     = i_en & ~o_stall;
  // An aligned memory instruction goes straight to REQ on its capture edge.
  assign start_mem   = capture & i_cu_memaccess & ~i_flush &
                       ~is_misaligned(i_exe_calc[1:0], i_cu_memwrite, i_ldop, i_sop);
  assign rsp_done    = (state_q == ST_RSP) & i_dmem_rvalid;
  assign ma_mis      = memaccess_q & is_misaligned(calc_q[1:0], memwrite_q, ldop_q, sop_q);
  assign wb_take_alu = (state_q == ST_IDLE) & valid_q;

  // NOTE: sequential state is only ever assigned with <=, so every flop sees pre-edge values.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_mem) state_d = ST_REQ;
      ST_REQ:  if (i_dmem_gnt) state_d = ST_RSP;
      ST_RSP:  if (i_dmem_rvalid) state_d = start_mem ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      memaccess_q <= 1'b0;
      memtoreg_q  <= MTR_ALU;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        regwrite_q  <= i_cu_regwrite & ~i_flush;
        memwrite_q  <= i_cu_memwrite & ~i_flush;
        memaccess_q <= i_cu_memaccess & ~i_flush;
        memtoreg_q  <= i_cu_memtoreg;
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; their control bits already qualify them.
  always_ff @(posedge i_aclk) begin
    if (capture) begin
      calc_q    <= i_exe_calc;
      wdata_q   <= i_exe_wdata;
      pcplus4_q <= i_pcplus4;
      rdest_q   <= i_rdest;
      ldop_q    <= i_ldop;
      sop_q     <= i_sop;
    end
  end

  assign o_dmem_we   = memwrite_q;
  assign o_dmem_addr = {calc_q[DATA_SIZE-1:2], 2'b00};
  assign o_ma_op     = (memtoreg_q == MTR_PC4) ? pcplus4_q : calc_q;

  always_comb begin
    o_dmem_be    = 4'b1111;
    o_dmem_wdata = wdata_q;
    if (memwrite_q) begin
      case (sop_q)
        SB: begin
          o_dmem_be    = 4'b0001 << calc_q[1:0];
          o_dmem_wdata = {4{wdata_q[7:0]}};
        end
        SH: begin
          o_dmem_be    = calc_q[1] ? 4'b1100 : 4'b0011;
          o_dmem_wdata = {2{wdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_offset (calc_q[1:0]),
    .i_ldop   (ldop_q),
    .o_data   (load_data)
  );

  // Anything other than a completed slot writes a bubble into WB.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wb_regwrite_q <= 1'b0;
      misaligned_q  <= 1'b0;
      wb_memtoreg_q <= MTR_ALU;
    end else begin
      wb_regwrite_q <= (wb_take_alu & regwrite_q & ~ma_mis) | (rsp_done & regwrite_q);
      misaligned_q  <= wb_take_alu & ma_mis;
      if (wb_take_alu | rsp_done) wb_memtoreg_q <= memtoreg_q;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (wb_take_alu | rsp_done) begin
      wb_alu_q     <= calc_q;
      wb_pcplus4_q <= pcplus4_q;
      wb_rdest_q   <= rdest_q;
    end
    if (rsp_done) wb_load_q <= load_data;
  end

  assign o_wb_alu      = wb_alu_q;
  assign o_wb_load     = wb_load_q;
  assign o_wb_pcplus4  = wb_pcplus4_q;
  assign o_wb_rdest    = wb_rdest_q;
  assign o_wb_memtoreg = wb_memtoreg_q;
  assign o_wb_regwrite = wb_regwrite_q;
  assign o_misaligned  = misaligned_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: a vector table of single instructions with a
// scripted memory handshake, plus hand-written reset and flush-under-stall sequences.
module tb_memory_access_unit;
  import multicore_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, flush = 1'b0;
  logic [31:0] exe_calc = '0, exe_wdata = '0, pcplus4 = '0;
  logic [4:0]  rdest = '0;
  logic        cu_regwrite = 1'b0, cu_memwrite = 1'b0, cu_memaccess = 1'b0;
  logic [1:0]  cu_memtoreg = 2'b00;
  t_ldop       ldop = LW;
  t_sop        sop = SW;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        stall, wb_regwrite, misaligned;
  logic [31:0] ma_op, wb_alu, wb_load, wb_pcplus4;
  logic [4:0]  wb_rdest;
  logic [1:0]  wb_memtoreg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .i_aclk(clk), .i_areset_n(rst_n), .i_en(en), .i_flush(flush),
    .i_exe_calc(exe_calc), .i_exe_wdata(exe_wdata), .i_pcplus4(pcplus4), .i_rdest(rdest),
    .i_cu_regwrite(cu_regwrite), .i_cu_memwrite(cu_memwrite), .i_cu_memaccess(cu_memaccess),
    .i_cu_memtoreg(cu_memtoreg), .i_ldop(ldop), .i_sop(sop),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_stall(stall), .o_ma_op(ma_op), .o_wb_alu(wb_alu), .o_wb_load(wb_load),
    .o_wb_pcplus4(wb_pcplus4), .o_wb_rdest(wb_rdest), .o_wb_memtoreg(wb_memtoreg),
    .o_wb_regwrite(wb_regwrite), .o_misaligned(misaligned)
  );

  typedef struct {
    string       name;
    logic [31:0] calc, wdata, pc4;
    logic [4:0]  rd;
    logic        rw, mw, ma, fl;
    logic [1:0]  mtr;
    t_ldop       ld;
    t_sop        so;
    logic [31:0] rdata;
    int          gnt_dly, rv_dly;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rw, exp_mis;
    logic [31:0] exp_wb, exp_ma_op;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string name, input logic [31:0] calc, wdata, pc4,
                              input logic [4:0] rd, input logic rw, mw, ma, fl,
                              input logic [1:0] mtr, input t_ldop ld, input t_sop so,
                              input logic [31:0] rdata, input int gd, rv,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic erw, emis, input logic [31:0] ewb, ema);
    vec_t v;
    v.name = name; v.calc = calc; v.wdata = wdata; v.pc4 = pc4; v.rd = rd;
    v.rw = rw; v.mw = mw; v.ma = ma; v.fl = fl; v.mtr = mtr; v.ld = ld; v.so = so;
    v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rv; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rw = erw; v.exp_mis = emis;
    v.exp_wb = ewb; v.exp_ma_op = ema;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input vec_t v);
    en = 1'b1; flush = v.fl; exe_calc = v.calc; exe_wdata = v.wdata; pcplus4 = v.pc4;
    rdest = v.rd; cu_regwrite = v.rw; cu_memwrite = v.mw; cu_memaccess = v.ma;
    cu_memtoreg = v.mtr; ldop = v.ld; sop = v.so;
  endtask

  task automatic check_wb(input vec_t v);
    logic [31:0] wb_val;
    wb_val = (v.mtr == 2'b01) ? wb_load : (v.mtr == 2'b10) ? wb_pcplus4 : wb_alu;
    check({v.name, ".wb_regwrite"}, 32'(wb_regwrite), 32'(v.exp_rw));
    check({v.name, ".misaligned"}, 32'(misaligned), 32'(v.exp_mis));
    if (v.exp_rw) begin
      check({v.name, ".wb_data"}, wb_val, v.exp_wb);
      check({v.name, ".wb_rdest"}, 32'(wb_rdest), 32'(v.rd));
      check({v.name, ".wb_memtoreg"}, 32'(wb_memtoreg), 32'(v.mtr));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cnt;
    stall_cnt = 0;
    @(posedge clk); #1;
    drive_instr(v);
    @(posedge clk); #1;
    en = 1'b0; flush = 1'b0;
    if (v.exp_req) begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        dmem_gnt = (k == v.gnt_dly);
        @(negedge clk);
        if (stall) stall_cnt++;
        check({v.name, ".req"}, 32'(dmem_req), 32'd1);
        check({v.name, ".addr"}, dmem_addr, v.exp_addr);
        if (k == 0) begin
          check({v.name, ".ma_op"}, ma_op, v.exp_ma_op);
          check({v.name, ".we"}, 32'(dmem_we), 32'(v.mw));
          check({v.name, ".be"}, 32'(dmem_be), 32'(v.exp_be));
          if (v.mw) check({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
        end
        @(posedge clk); #1;
      end
      dmem_gnt = 1'b0;
      for (int j = 1; j <= v.rv_dly; j++) begin
        dmem_rvalid = (j == v.rv_dly);
        dmem_rdata  = (j == v.rv_dly) ? v.rdata : 32'h0;
        @(negedge clk);
        if (stall) stall_cnt++;
        if (j == 1) check({v.name, ".req_after_gnt"}, 32'(dmem_req), 32'd0);
        if (j == v.rv_dly) check({v.name, ".stall_in_rvalid"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      check({v.name, ".stall_span"}, 32'(stall_cnt), 32'(v.gnt_dly + v.rv_dly));
    end else begin
      @(negedge clk);
      check({v.name, ".ma_op"}, ma_op, v.exp_ma_op);
      check({v.name, ".no_req"}, 32'(dmem_req), 32'd0);
      check({v.name, ".no_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_wb(v);
    @(posedge clk); #1;
    @(negedge clk);
    check({v.name, ".bubble_regwrite"}, 32'(wb_regwrite), 32'd0);
    check({v.name, ".bubble_misaligned"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //            name    calc          wdata         pc4   rd rw mw ma fl mtr    ld   so  rdata         gd rv req addr         be       wdata         rw mis wb            ma_op
    vecs[0]  = mk("add",  32'h1234,     0,            4,    1, 1, 0, 0, 0, 2'b00, LW,  SW, 0,            0, 0, 0, 0,           4'hx,    0,            1, 0, 32'h1234,     32'h1234);
    vecs[1]  = mk("lb",   32'h103,      0,            8,    2, 1, 0, 1, 0, 2'b01, LB,  SB, 32'h80FFFF00, 2, 3, 1, 32'h100,     4'b1111, 0,            1, 0, 32'hFFFFFF80, 32'h103);
    vecs[2]  = mk("lhu",  32'h202,      0,            12,   3, 1, 0, 1, 0, 2'b01, LHU, SB, 32'hBEEF0000, 0, 1, 1, 32'h200,     4'b1111, 0,            1, 0, 32'h0000BEEF, 32'h202);
    vecs[3]  = mk("sh",   32'h202,      32'h0000ABCD, 16,   4, 0, 1, 1, 0, 2'b00, LW,  SH, 0,            1, 2, 1, 32'h200,     4'b1100, 32'hABCDABCD, 0, 0, 0,            32'h202);
    vecs[4]  = mk("lw_mis", 32'h101,    0,            20,   5, 1, 0, 1, 0, 2'b01, LW,  SW, 0,            0, 0, 0, 0,           4'hx,    0,            0, 1, 0,            32'h101);
    vecs[5]  = mk("jal",  32'h999,      0,            32'h44, 6, 1, 0, 0, 0, 2'b10, LW, SW, 0,           0, 0, 0, 0,           4'hx,    0,            1, 0, 32'h44,       32'h44);
    vecs[6]  = mk("sb",   32'h43,       32'h123456A5, 24,   7, 0, 1, 1, 0, 2'b00, LW,  SB, 0,            1, 1, 1, 32'h40,      4'b1000, 32'hA5A5A5A5, 0, 0, 0,            32'h43);
    vecs[7]  = mk("lh",   32'h30,       0,            28,   8, 1, 0, 1, 0, 2'b01, LH,  SB, 32'h12348001, 0, 2, 1, 32'h30,      4'b1111, 0,            1, 0, 32'hFFFF8001, 32'h30);
    vecs[8]  = mk("lbu",  32'h51,       0,            32,   9, 1, 0, 1, 0, 2'b01, LBU, SB, 32'h0000F100, 3, 1, 1, 32'h50,      4'b1111, 0,            1, 0, 32'h000000F1, 32'h51);
    vecs[9]  = mk("sw",   32'h60,       32'hDEADBEEF, 36,  10, 0, 1, 1, 0, 2'b00, LW,  SW, 0,            0, 1, 1, 32'h60,      4'b1111, 32'hDEADBEEF, 0, 0, 0,            32'h60);
    vecs[10] = mk("sh_mis", 32'h61,     32'h1111,     40,  11, 0, 1, 1, 0, 2'b00, LW,  SH, 0,            0, 0, 0, 0,           4'hx,    0,            0, 1, 0,            32'h61);
    vecs[11] = mk("lw",   32'h70,       0,            44,  12, 1, 0, 1, 0, 2'b01, LW,  SW, 32'hCAFEF00D, 1, 1, 1, 32'h70,      4'b1111, 0,            1, 0, 32'hCAFEF00D, 32'h70);
    vecs[12] = mk("flush", 32'h74,      0,            48,  13, 1, 0, 1, 1, 2'b01, LW,  SW, 0,            0, 0, 0, 0,           4'hx,    0,            0, 0, 0,            32'h74);
    vecs[13] = mk("lh_mis", 32'h33,     0,            52,  14, 1, 0, 1, 0, 2'b01, LH,  SW, 0,            0, 0, 0, 0,           4'hx,    0,            0, 1, 0,            32'h33);
    vecs[14] = mk("lb_pos", 32'h102,    0,            56,  15, 1, 0, 1, 0, 2'b01, LB,  SW, 32'h007F0000, 1, 2, 1, 32'h100,     4'b1111, 0,            1, 0, 32'h0000007F, 32'h102);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.req", 32'(dmem_req), 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("reset.misaligned", 32'(misaligned), 32'd0);
    check("reset.wb_memtoreg", 32'(wb_memtoreg), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset clears a live WB slot (regwrite=1, memtoreg=10)
    @(posedge clk); #1;
    drive_instr(vecs[5]);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    check("rst_wb.pre_regwrite", 32'(wb_regwrite), 32'd1);
    check("rst_wb.pre_memtoreg", 32'(wb_memtoreg), 32'd2);
    rst_n = 1'b0; #1;
    check("rst_wb.regwrite", 32'(wb_regwrite), 32'd0);
    check("rst_wb.memtoreg", 32'(wb_memtoreg), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during RSP aborts the transaction; a late rvalid is ignored
    @(posedge clk); #1;
    drive_instr(vecs[11]);
    @(posedge clk); #1;
    en = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("rst_rsp.pre_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0; #1;
    check("rst_rsp.req", 32'(dmem_req), 32'd0);
    check("rst_rsp.stall", 32'(stall), 32'd0);
    check("rst_rsp.wb_regwrite", 32'(wb_regwrite), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("stray_rvalid.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    check("stray_rvalid.wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("stray_rvalid.req", 32'(dmem_req), 32'd0);

    // Flush held high during a stalled load does not disturb it
    @(posedge clk); #1;
    drive_instr(vecs[1]);
    @(posedge clk); #1;
    v = vecs[11]; v.fl = 1'b1; v.rd = 5'd20;
    drive_instr(v);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("flush_stall.req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FFFF00;
    @(negedge clk);
    check("flush_stall.stall_in_rvalid", 32'(stall), 32'd0);
    @(posedge clk); #1;
    en = 1'b0; flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    check("flush_stall.wb_regwrite", 32'(wb_regwrite), 32'd1);
    check("flush_stall.wb_rdest", 32'(wb_rdest), 32'd2);
    check("flush_stall.wb_load", wb_load, 32'hFFFFFF80);
    check("flush_stall.bubble_no_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_stall.bubble_regwrite", 32'(wb_regwrite), 32'd0);
    check("flush_stall.bubble_stall", 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
